// File: rtl/fifo_stream_drain.sv
// Drain stage: pops a 1-cycle-latency fifo and re-presents its words on a valid/ready stream with burst framing.
// Latency: rd_en -> m_valid is 2 cycles minimum; sustained 1 beat/cycle while the fifo is non-empty and m_ready=1.
// Backpressure: a 2-entry buffer plus an in-flight flag gate rd_en so no word is lost or duplicated; m_data holds while stalled.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int BEAT_W     = 4,
  parameter int XFER_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_err,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [BEAT_W-1:0]     beat_cnt,
  output logic [XFER_W-1:0]     xfer_cnt,
  output logic                  busy,
  output logic                  err_spurious,
  output logic                  err_underflow
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // Two buffer slots addressed by head pointer; the tail is head offset by occupancy.
  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [XFER_W-1:0]     xfer_q, xfer_d;
  logic                  err_sp_q, err_sp_d;
  logic                  err_uf_q, err_uf_d;

  logic       pop;
  logic       capture;
  logic       tail;
  logic [2:0] space;

  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign capture = fifo_valid & inflight_q;
  assign tail    = head_q ^ occ_q[0];

  // Free slots counting the word already in flight; a same-cycle pop frees one more.
  // occ + inflight never exceeds 2, so this cannot go negative.
  assign space = 3'd2 - {1'b0, occ_q} - {2'b0, inflight_q} + {2'b0, pop};

  // Held low during reset so nothing is popped while state is being cleared.
  assign fifo_rd_en = rst & enable & ~fifo_empty & (space != 3'd0);

  assign m_data        = head_q ? mem1_q : mem0_q;
  assign m_last        = m_valid & (beat_q == LAST_BEAT);
  assign beat_cnt      = beat_q;
  assign xfer_cnt      = xfer_q;
  assign busy          = m_valid | inflight_q;
  assign err_spurious  = err_sp_q;
  assign err_underflow = err_uf_q;

  // Next-state for buffer, pointers, counters and sticky error flags.
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    head_d   = head_q ^ pop;
    occ_d    = occ_q + {1'b0, capture} - {1'b0, pop};
    beat_d   = beat_q;
    xfer_d   = xfer_q + XFER_W'(pop);
    err_sp_d = clear_err ? 1'b0 : err_sp_q;
    err_uf_d = clear_err ? 1'b0 : err_uf_q;

    if (capture) begin
      if (tail) begin
        mem1_d = fifo_data;
      end else begin
        mem0_d = fifo_data;
      end
    end

    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    if (fifo_valid & ~inflight_q) begin
      err_sp_d = 1'b1;
    end
    if (fifo_underflow) begin
      err_uf_d = 1'b1;
    end
  end

  // State registers; reset discards buffered and in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0_q     <= '0;
      mem1_q     <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      xfer_q     <= '0;
      err_sp_q   <= 1'b0;
      err_uf_q   <= 1'b0;
    end else begin
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      xfer_q     <= xfer_d;
      err_sp_q   <= err_sp_d;
      err_uf_q   <= err_uf_d;
    end
  end

endmodule
